// File: rtl/arm_rf_pkg.sv
// arm_rf_pkg: shared widths and types for the ARM general register file
package arm_rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/arm_reg32.sv
// arm_reg32: one DATA_W register with asynchronous active-low clear and load enable
//   Clk   rising-edge clock
//   Rst_n asynchronous clear, active-low
//   Ld    load enable
//   D     data to load
//   Q     stored value
module arm_reg32
  import arm_rf_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Ld,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) Q <= '0;
    else if (Ld) Q <= D;
endmodule

// File: rtl/arm_reg_file.sv
// arm_reg_file: 16 x 32 register file, two combinational read ports, one clocked write port
//   Clk   rising-edge clock
//   Rst_n asynchronous reset, active-low; clears all registers
//   A, B  read data for regA, regB
//   C     write data, loaded into R[deC] when Ld = 1
//   regA, regB read selects; deC write select
//   Ld    write enable
//   Define ARM_REG_FILE_BYPASS_EN to forward C onto A/B when a read hits the register being written.
module arm_reg_file
  import arm_rf_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic [ADDR_W-1:0] regA,
  input  logic [ADDR_W-1:0] regB,
  input  logic [ADDR_W-1:0] deC,
  input  logic              Ld
);
  logic [NUM_REGS-1:0] ldDec;
  word_t regs [NUM_REGS];
  always_comb ldDec = Ld ? (NUM_REGS'(1) << deC) : '0;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    arm_reg32 u_reg (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .Ld   (ldDec[i]),
      .D    (C),
      .Q    (regs[i])
    );
  end
`ifdef ARM_REG_FILE_BYPASS_EN
  always_comb begin
    A = (Ld && regA == deC) ? C : regs[regA];
    B = (Ld && regB == deC) ? C : regs[regB];
  end
`else
  always_comb begin
    A = regs[regA];
    B = regs[regB];
  end
`endif
endmodule

// File: tb/tb_arm_reg_file.sv
// tb_arm_reg_file: directed self-checking bench for arm_reg_file
`timescale 1ns/1ps
module tb_arm_reg_file;
  logic        Clk, Rst_n, Ld;
  logic [31:0] A, B, C;
  logic [3:0]  regA, regB, deC;
  int errors = 0;
  int checks = 0;

  arm_reg_file dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .A    (A),
    .B    (B),
    .C    (C),
    .regA (regA),
    .regB (regB),
    .deC  (deC),
    .Ld   (Ld)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 0; Ld = 1; C = 32'd55; deC = 4'd2; regA = 4'd2; regB = 4'd0;
    #1;
    chk("reset_A", A, 0);
    chk("reset_B", B, 0);
    tick();
    chk("write_during_reset", A, 0);
    Ld = 0;
    @(negedge Clk);
    Rst_n = 1;
    tick();
    chk("after_release_R2", A, 0);
    @(negedge Clk);
    Ld = 1;
    for (int k = 0; k < 16; k++) begin
      deC = 4'(k);
      C = 32'(100 + 4 * k);
      @(negedge Clk);
    end
    Ld = 0;
    for (int k = 0; k < 16; k++) begin
      regA = 4'(k);
      regB = 4'(15 - k);
      #1;
      chk($sformatf("fill_A%0d", k), A, 32'(100 + 4 * k));
      chk($sformatf("fill_B%0d", 15 - k), B, 32'(160 - 4 * k));
    end
    @(negedge Clk);
    Ld = 1; deC = 4'd10; C = 32'd35;
    @(negedge Clk);
    Ld = 0;
    regA = 4'd10; regB = 4'd9;
    #1;
    chk("overwrite_R10", A, 35);
    chk("neighbor_R9", B, 136);
    regB = 4'd11;
    #1;
    chk("neighbor_R11", B, 144);
    Ld = 0; deC = 4'd3; C = 32'hDEADBEEF;
    repeat (3) @(negedge Clk);
    regA = 4'd3;
    #1;
    chk("ld_disabled_R3", A, 112);
    regA = 4'd5; regB = 4'd6; deC = 4'd5; C = 32'd7; Ld = 1;
    #1;
`ifdef ARM_REG_FILE_BYPASS_EN
    chk("same_cycle_before", A, 7);
`else
    chk("same_cycle_before", A, 120);
`endif
    chk("same_cycle_other_port", B, 124);
    @(negedge Clk);
    Ld = 0;
    #1;
    chk("same_cycle_after", A, 7);
    regA = 4'd15; regB = 4'd15;
    #1;
    chk("dual_read_A", A, 160);
    chk("dual_read_B", B, 160);
    @(posedge Clk);
    #2;
    Rst_n = 0;
    #1;
    chk("async_reset_A15", A, 0);
    chk("async_reset_B15", B, 0);
    for (int k = 0; k < 16; k++) begin
      regA = 4'(k);
      regB = 4'(15 - k);
      #0.1;
      chk($sformatf("reset_sweep_A%0d", k), A, 0);
      chk($sformatf("reset_sweep_B%0d", 15 - k), B, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
